// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: decode-side read ports, writeback write port,
// and the Clear/Busy/WriteDropped sideband.
interface regfile_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic                  Clear;
  logic                  Busy;
  logic                  WriteDropped;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, Clear,
    input  ReadData1, ReadData2, Busy, WriteDropped
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, Clear,
    output ReadData1, ReadData2, Busy, WriteDropped
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with optional hardwired r0, optional
// write-to-read bypass and a one-entry-per-cycle sequential Clear engine.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | normal operation; Clear starts a sweep (entry 0 on that edge)
// CLEARING | zeroing entry[cnt_q] each edge; writes dropped, bypass off
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 0
) (
  input logic             Clk,
  input logic             Reset,
  regfile_param_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH-1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_req;
  logic                  wr_en;
  logic                  wr_zero;
  logic [DATA_WIDTH-1:0] rd1, rd2;

  assign clr_req = (state_q == IDLE) && bus.Clear;
  assign wr_zero = (ZERO_REG != 0) && (bus.WriteRegister == '0);
  // The request edge itself already belongs to the clear, so writes are refused there too.
  assign wr_en   = bus.RegWrite && !busy_q && !clr_req && !wr_zero;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    clr_en   = 1'b0;
    clr_addr = cnt_q;
    drop_d   = bus.RegWrite && (busy_q || clr_req);
    case (state_q)
      IDLE: begin
        if (bus.Clear) begin
          clr_en   = 1'b1;
          clr_addr = '0;
          cnt_d    = CNT_ONE;
          busy_d   = 1'b1;
          state_d  = CLEARING;
        end
      end
      CLEARING: begin
        clr_en = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en)  mem_q[bus.WriteRegister] <= bus.WriteData;
      if (clr_en) mem_q[clr_addr] <= '0;
    end
  end

  always_comb begin
    rd1 = mem_q[bus.ReadRegister1];
    if ((BYPASS != 0) && wr_en && (bus.ReadRegister1 == bus.WriteRegister)) rd1 = bus.WriteData;
    if ((ZERO_REG != 0) && (bus.ReadRegister1 == '0)) rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[bus.ReadRegister2];
    if ((BYPASS != 0) && wr_en && (bus.ReadRegister2 == bus.WriteRegister)) rd2 = bus.WriteData;
    if ((ZERO_REG != 0) && (bus.ReadRegister2 == '0)) rd2 = '0;
  end

  assign bus.ReadData1    = rd1;
  assign bus.ReadData2    = rd2;
  assign bus.Busy         = busy_q;
  assign bus.WriteDropped = drop_q;
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file.
- Provides: configurable data width and depth; optional hardwired register zero; optional write-to-read bypass; asynchronous reset clearing all entries; and a sequential Clear engine that zeros the array one entry per cycle, with a Busy indication.
- Sits in the CPU datapath between decode (read addresses) and writeback (write port).

Parameters:
- DATA_WIDTH, 32: bits per register.
- ADDR_WIDTH, 5: address bits. Depth DEPTH = 2**ADDR_WIDTH.
- ZERO_REG, 1: 1 = register 0 reads 0 and ignores writes. 0 = register 0 is ordinary storage.
- BYPASS, 0: 1 = a read of the address being written this cycle (RegWrite accepted) returns WriteData combinationally. 0 = the read returns the old value until the clock edge.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high; clears all state.
- ReadRegister1  input  ADDR_WIDTH  read port 1 address.
- ReadRegister2  input  ADDR_WIDTH  read port 2 address.
- ReadData1  output  DATA_WIDTH  combinational read data, port 1.
- ReadData2  output  DATA_WIDTH  combinational read data, port 2.
- WriteRegister  input  ADDR_WIDTH  write address.
- WriteData  input  DATA_WIDTH  write data.
- RegWrite  input  1  write enable, sampled at posedge Clk.
- Clear  input  1  request a sequential clear of the whole array, sampled at posedge Clk.
- Busy  output  1  high while the Clear engine runs.
- WriteDropped  output  1  registered one-cycle pulse: a RegWrite was ignored because Busy was high.

Behaviour:
- Reset (asynchronous, immediate):
  - All DEPTH entries = 0.
  - FSM = IDLE, clear counter = 0.
  - Busy = 0, WriteDropped = 0.
  - ReadData1/2 reflect the zeroed array immediately.
- Reads: purely combinational, zero-latency from the address, and from WriteData when bypass applies.
  - If ZERO_REG = 1 and the address is 0, output 0 regardless of stored content or bypass.
  - If BYPASS = 1, address == WriteRegister, RegWrite = 1 and Busy = 0, output WriteData.
  - Otherwise output the stored entry.
- Writes: on posedge Clk, when RegWrite = 1 and Busy = 0, entry[WriteRegister] <= WriteData.
  - The write is skipped when ZERO_REG = 1 and WriteRegister = 0.
  - New data is visible on the read ports after the edge (latency 1 with BYPASS = 0, latency 0 with BYPASS = 1).
- FSM states IDLE and CLEARING:
  - IDLE, Clear = 1 at posedge: entry[0] <= 0 on that edge, counter <= 1, Busy <= 1, go to CLEARING. A RegWrite on the same edge is ignored and WriteDropped pulses.
  - CLEARING: each posedge, entry[counter] <= 0 and counter increments.
  - When counter == DEPTH-1, that entry is cleared, Busy <= 0 and the FSM returns to IDLE.
  - Busy is therefore high for exactly DEPTH-1 cycles after the request edge; the total clear takes DEPTH edges including the request edge.
  - Clear asserted during CLEARING is ignored: no restart, no extension.
  - Clear asserted on the cycle Busy falls is treated as a new request from IDLE.
  - The counter is ADDR_WIDTH bits and must not wrap past DEPTH-1.
- Writes during clear:
  - Any posedge with RegWrite = 1 while Busy = 1 (or on the request edge) is dropped. The entry is unchanged apart from clearing.
  - WriteDropped = 1 for the following cycle only.
  - WriteDropped is 0 otherwise, including for writes to register 0 with ZERO_REG = 1; those are legal no-ops, not drops.
- Reads during clear return current stored content: already-cleared entries read 0, uncleared entries read their old values. Bypass is disabled while Busy = 1.
- Reset asserted mid-clear: everything zeroes at once and the FSM returns to IDLE with Busy = 0. No partial state survives.
- Simultaneous read and write of the same address with BYPASS = 0: old value before the edge, new value after.
- Both read ports may address the same entry; each is independent.
- All address values 0..DEPTH-1 are valid; there is no out-of-range case.

Test Plan:
- Defaults (32/5, ZERO_REG = 1, BYPASS = 0). Write 42 then 15 to r2; read r2 on both ports. -> 15/15 after the second edge. Before that edge -> 42/42.
- RegWrite = 0 with WriteRegister = 6, WriteData = 17, after r6 = 15 -> r6 still 15. Write r5 = 15, r6 = 17, read (r5, r6) -> 15/17, with no aliasing across all 32 addresses (walking-ones address sweep).
- Write 15 to r0 -> reads 0, WriteDropped = 0. Rebuild with ZERO_REG = 0 -> r0 reads 15.
- BYPASS = 1: RegWrite = 1, WriteRegister = 9, WriteData = 0xDEADBEEF, ReadRegister1 = 9 before the edge -> ReadData1 = 0xDEADBEEF. ReadRegister2 = 0 -> 0.
- Fill r1..r31 with their index, pulse Clear:
  - Busy high for 31 cycles.
  - A write of 99 to r31 during Busy -> WriteDropped pulses, r31 ends at 0.
  - After Busy falls, all reads are 0. A Clear re-pulsed mid-run does not extend Busy.
- Assert Reset 10 cycles into a clear, with r20 = 7 not yet cleared -> r20 = 0 immediately, Busy = 0 immediately. The next write of 5 to r3 succeeds.
